// File: rtl/mc_control_unit_pkg.sv
// mc_control_unit_pkg: shared encodings for the multicycle controller and its stall timer.
// Opcode 3'b111 with the immediate bit clear is HALT; with it set it is reserved (illegal).
package mc_control_unit_pkg;
  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBK, ST_PAUSE, ST_HALT
  } state_t;
  typedef enum logic [2:0] {
    OPCODE_ADD, OPCODE_SUB, OPCODE_NAND, OPCODE_LOAD,
    OPCODE_STORE, OPCODE_JMP, OPCODE_JZ, OPCODE_HALT
  } opcode_t;
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_ILLEGAL = 2'd1, ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ALU_NULL = 2'd0, ALU_ADD = 2'd1, ALU_SUB = 2'd2, ALU_NAND = 2'd3;
  localparam logic PC_SRC_INC = 1'b0, PC_SRC_JUMP = 1'b1;
  localparam logic MEM_ADDR_PC = 1'b0, MEM_ADDR_IR = 1'b1;
  localparam logic REG_SRC_ALU = 1'b0, REG_SRC_RAM = 1'b1;
  function automatic logic [1:0] alu_of(input opcode_t op);
    return op == OPCODE_SUB ? ALU_SUB : op == OPCODE_NAND ? ALU_NAND : ALU_ADD;
  endfunction
endpackage

// File: rtl/mc_stall_timer.sv
// mc_stall_timer: counts consecutive stall cycles; expired flags the cycle that would be the TIMEOUT-th.
module mc_stall_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign expired = (TIMEOUT != 0) && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle CPU control FSM with mem_ready stalls, stall timeout,
// single-step pause/resume and sticky error status.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int INSTR_W  = 8,
  parameter int REG_AW   = 2,
  parameter int ADDR_W   = 5,
  parameter int END_ADDR = 2**ADDR_W - 1,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic              zero_flag,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mem_ready,
  input  logic              step_en,
  input  logic              resume,
  output logic              pc_write,
  output logic              pc_src,
  output logic              ir_write,
  output logic              reg_write,
  output logic              reg_src,
  output logic [REG_AW-1:0] reg_dest,
  output logic [1:0]        alu_op,
  output logic [REG_AW-1:0] alu_src1,
  output logic [REG_AW-1:0] alu_src2,
  output logic              imm_sel,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_addr_src,
  output logic              instr_done,
  output logic              halted,
  output logic [1:0]        error,
  output logic [2:0]        state_dbg
);
  state_t state, nxt;
  opcode_t op;
  logic imm, illegal, is_jump, is_mem, stall, expired, timeout, done;
  logic [REG_AW-1:0] src1, src2;
  assign op      = opcode_t'(instruction[INSTR_W-1 -: 3]);
  assign imm     = instruction[INSTR_W-4];
  assign src1    = instruction[INSTR_W-5 -: REG_AW];
  assign src2    = instruction[REG_AW-1:0];
  assign illegal = op == OPCODE_HALT && imm;
  assign is_jump = op == OPCODE_JMP || op == OPCODE_JZ;
  assign is_mem  = op == OPCODE_LOAD || op == OPCODE_STORE;
  assign stall   = (state == ST_FETCH || state == ST_MEM) && !mem_ready;
  assign timeout = stall && expired;
  // a non-timeout stall keeps the state, so anything else is a state change that clears the count
  mc_stall_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(reset), .clear(!stall || timeout), .en(stall), .expired(expired)
  );
  always_comb begin
    done = 1'b0;
    nxt  = state;
    case (state)
      ST_FETCH:   nxt = mem_ready ? ST_DECODE : timeout ? ST_HALT : ST_FETCH;
      ST_DECODE:  nxt = op == OPCODE_HALT ? ST_HALT : is_mem ? ST_MEM : ST_EXECUTE;
      ST_EXECUTE: begin
        done = is_jump;
        nxt  = ST_WRITEBK;
      end
      ST_MEM: begin
        done = mem_ready && op == OPCODE_STORE;
        nxt  = timeout ? ST_HALT : mem_ready ? ST_WRITEBK : ST_MEM;
      end
      ST_WRITEBK: done = 1'b1;
      ST_PAUSE:   nxt = resume ? ST_FETCH : ST_PAUSE;
      default:    nxt = ST_HALT;
    endcase
    if (done) nxt = pc == ADDR_W'(END_ADDR) ? ST_HALT : step_en ? ST_PAUSE : ST_FETCH;
  end
  always_comb begin
    pc_write     = 1'b0;
    pc_src       = PC_SRC_INC;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_src      = REG_SRC_ALU;
    reg_dest     = '0;
    alu_op       = ALU_NULL;
    alu_src1     = '0;
    alu_src2     = '0;
    imm_sel      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_src = MEM_ADDR_PC;
    case (state)
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_EXECUTE:
        if (is_jump) begin
          pc_write = op == OPCODE_JMP || zero_flag;
          pc_src   = PC_SRC_JUMP;
        end else begin
          alu_op   = alu_of(op);
          alu_src1 = src1;
          alu_src2 = src2;
          imm_sel  = imm;
        end
      ST_MEM: begin
        mem_addr_src = MEM_ADDR_IR;
        mem_read     = op == OPCODE_LOAD;
        mem_write    = op == OPCODE_STORE;
      end
      ST_WRITEBK: begin
        reg_write = 1'b1;
        reg_src   = op == OPCODE_LOAD ? REG_SRC_RAM : REG_SRC_ALU;
        reg_dest  = op == OPCODE_LOAD ? '0 : src1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_FETCH;
      error <= ERR_NONE;
    end else begin
      state <= nxt;
      if (error == ERR_NONE)
        error <= state == ST_DECODE && illegal ? ERR_ILLEGAL : timeout ? ERR_TIMEOUT : ERR_NONE;
    end
  assign instr_done = done;
  assign halted     = state == ST_HALT;
  assign state_dbg  = state;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: scoreboard bench; per-cycle expected control vectors are queued as
// stimulus is applied and compared against the DUT outputs on the falling edge.
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] instruction = '0;
  logic [4:0] pc = '0;
  logic zero_flag = 1'b0, mem_ready = 1'b1, step_en = 1'b0, resume = 1'b0;
  logic pc_write, pc_src, ir_write, reg_write, reg_src, imm_sel, mem_read, mem_write;
  logic mem_addr_src, instr_done, halted;
  logic [1:0] reg_dest, alu_op, alu_src1, alu_src2, error;
  logic [2:0] state_dbg;
  typedef struct packed {
    logic [2:0] st;
    logic pcw, pcs, irw, rw, rs;
    logic [1:0] rd, aop, s1, s2;
    logic imm, mr, mw, mas, done, halt;
    logic [1:0] err;
  } obs_t;
  obs_t obs;
  obs_t sb[$];
  int n_chk = 0, n_pass = 0;
  logic [1:0] cur_err = 2'd0;
  mc_control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero_flag(zero_flag), .pc(pc),
    .mem_ready(mem_ready), .step_en(step_en), .resume(resume), .pc_write(pc_write),
    .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write), .reg_src(reg_src),
    .reg_dest(reg_dest), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .imm_sel(imm_sel), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr_src(mem_addr_src), .instr_done(instr_done), .halted(halted), .error(error),
    .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  assign obs = {state_dbg, pc_write, pc_src, ir_write, reg_write, reg_src, reg_dest, alu_op,
                alu_src1, alu_src2, imm_sel, mem_read, mem_write, mem_addr_src, instr_done,
                halted, error};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic obs_t idle(input logic [2:0] st);
    obs_t e = '0;
    e.st   = st;
    e.halt = st == 3'd6;
    e.err  = cur_err;
    return e;
  endfunction
  function automatic obs_t e_fetch(input logic rdy);
    obs_t e = idle(3'd0);
    e.mr  = 1'b1;
    e.irw = rdy;
    e.pcw = rdy;
    return e;
  endfunction
  function automatic obs_t e_alu(input logic [1:0] aop, input logic [1:0] s1, input logic [1:0] s2, input logic imm);
    obs_t e = idle(3'd2);
    e.aop = aop;
    e.s1  = s1;
    e.s2  = s2;
    e.imm = imm;
    return e;
  endfunction
  function automatic obs_t e_jump(input logic pcw);
    obs_t e = idle(3'd2);
    e.pcs  = 1'b1;
    e.pcw  = pcw;
    e.done = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_mem(input logic load, input logic rdy);
    obs_t e = idle(3'd3);
    e.mas  = 1'b1;
    e.mr   = load;
    e.mw   = !load;
    e.done = !load && rdy;
    return e;
  endfunction
  function automatic obs_t e_wb(input logic load, input logic [1:0] rd);
    obs_t e = idle(3'd4);
    e.rw   = 1'b1;
    e.rs   = load;
    e.rd   = rd;
    e.done = 1'b1;
    return e;
  endfunction
  task automatic cyc(input string tag, input obs_t e);
    obs_t x;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk(tag, obs, x);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset   = 1'b1;
    cur_err = 2'd0;
    cyc("reset", idle(3'd0));
    reset = 1'b0;
  endtask
  task automatic run_alu(input string tag, input opcode_t op, input logic imm,
                         input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] aop);
    instruction = {op, imm, s1, s2};
    cyc({tag, "_fetch"}, e_fetch(1'b1));
    cyc({tag, "_decode"}, idle(3'd1));
    cyc({tag, "_exec"}, e_alu(aop, s1, s2, imm));
    cyc({tag, "_wb"}, e_wb(1'b0, s1));
  endtask
  task automatic run_jump(input string tag, input opcode_t op, input logic zf, input logic pcw);
    instruction = {op, 5'd3};
    zero_flag   = zf;
    cyc({tag, "_fetch"}, e_fetch(1'b1));
    cyc({tag, "_decode"}, idle(3'd1));
    cyc({tag, "_exec"}, e_jump(pcw));
  endtask
  task automatic run_mem(input string tag, input opcode_t op, input int stalls);
    instruction = {op, 5'd5};
    cyc({tag, "_fetch"}, e_fetch(1'b1));
    cyc({tag, "_decode"}, idle(3'd1));
    mem_ready = 1'b0;
    repeat (stalls) cyc({tag, "_stall"}, e_mem(op == OPCODE_LOAD, 1'b0));
    mem_ready = 1'b1;
    cyc({tag, "_mem"}, e_mem(op == OPCODE_LOAD, 1'b1));
    if (op == OPCODE_LOAD) cyc({tag, "_wb"}, e_wb(1'b1, 2'd0));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    run_alu("add", OPCODE_ADD, 1'b0, 2'd1, 2'd2, ALU_ADD);
    run_alu("subi", OPCODE_SUB, 1'b1, 2'd3, 2'd1, ALU_SUB);
    run_alu("nand", OPCODE_NAND, 1'b0, 2'd2, 2'd0, ALU_NAND);
    run_jump("jz0", OPCODE_JZ, 1'b0, 1'b0);
    run_jump("jz1", OPCODE_JZ, 1'b1, 1'b1);
    run_jump("jmp", OPCODE_JMP, 1'b0, 1'b1);
    run_mem("load3", OPCODE_LOAD, 3);
    run_mem("store2", OPCODE_STORE, 2);
    run_mem("load14", OPCODE_LOAD, 14);
    cyc("after_load", e_fetch(1'b1));
    do_reset();
    step_en = 1'b1;
    run_alu("step", OPCODE_ADD, 1'b0, 2'd1, 2'd2, ALU_ADD);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) step_en = 1'b0;
      cyc("pause", idle(3'd5));
    end
    resume = 1'b1;
    cyc("pause_resume", idle(3'd5));
    resume = 1'b0;
    run_alu("resumed", OPCODE_ADD, 1'b0, 2'd1, 2'd2, ALU_ADD);
    cyc("resumed_fetch", e_fetch(1'b1));
    do_reset();
    instruction = {OPCODE_HALT, 5'd0};
    cyc("halt_fetch", e_fetch(1'b1));
    cyc("halt_decode", idle(3'd1));
    resume = 1'b1;
    cyc("halt_op", idle(3'd6));
    cyc("halt_op_resume", idle(3'd6));
    resume = 1'b0;
    do_reset();
    instruction = {OPCODE_HALT, 1'b1, 4'd0};
    cyc("ill_fetch", e_fetch(1'b1));
    cyc("ill_decode", idle(3'd1));
    cur_err = ERR_ILLEGAL;
    resume  = 1'b1;
    repeat (3) cyc("ill_halt", idle(3'd6));
    resume = 1'b0;
    do_reset();
    mem_ready = 1'b0;
    repeat (15) cyc("to_fetch", e_fetch(1'b0));
    cur_err   = ERR_TIMEOUT;
    mem_ready = 1'b1;
    resume    = 1'b1;
    repeat (3) cyc("to_halt", idle(3'd6));
    resume = 1'b0;
    do_reset();
    run_alu("post_to", OPCODE_NAND, 1'b1, 2'd3, 2'd3, ALU_NAND);
    instruction = {OPCODE_STORE, 5'd9};
    cyc("tos_fetch", e_fetch(1'b1));
    cyc("tos_decode", idle(3'd1));
    mem_ready = 1'b0;
    repeat (15) cyc("tos_stall", e_mem(1'b0, 1'b0));
    cur_err   = ERR_TIMEOUT;
    mem_ready = 1'b1;
    cyc("tos_halt", idle(3'd6));
    do_reset();
    pc      = 5'd31;
    step_en = 1'b1;
    run_alu("end", OPCODE_SUB, 1'b0, 2'd2, 2'd1, ALU_SUB);
    resume = 1'b1;
    repeat (2) cyc("end_halt", idle(3'd6));
    resume  = 1'b0;
    step_en = 1'b0;
    do_reset();
    run_jump("endj", OPCODE_JMP, 1'b0, 1'b1);
    cyc("endj_halt", idle(3'd6));
    pc = 5'd0;
    do_reset();
    instruction = {OPCODE_LOAD, 5'd7};
    cyc("mid_fetch", e_fetch(1'b1));
    cyc("mid_decode", idle(3'd1));
    mem_ready = 1'b0;
    repeat (2) cyc("mid_stall", e_mem(1'b1, 1'b0));
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_dbg), 32'(ST_FETCH));
    chk("async_rst_en", 32'({pc_write, ir_write, reg_write, mem_read, mem_write}), 32'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    cyc("mid_rst_hold", idle(3'd0));
    reset = 1'b0;
    cyc("mid_release", e_fetch(1'b1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
